// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : run_controller
//  Purpose  : Debounced run/halt/single-step sequencer for the pipelined core,
//             driving a one-cycle clock enable plus an enabled-cycle counter.
//             Optional PC breakpoint built when RUN_CTRL_BREAKPOINT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pb_run,
    input  logic            pb_step,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            bp_valid,
    output logic            cpu_en,
    output logic            halted,
    output logic [1:0]      state,
    output logic [31:0]     cycle_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_cycle_cnt;
    logic [1:0]  w_pb_raw;
    logic [1:0]  w_press;
    logic        w_run_press;
    logic        w_step_press;
    logic        w_bp_hit;
    logic        w_cpu_en;

    assign w_pb_raw = {pb_step, pb_run};

    // Index 0 = run button, index 1 = step button.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]       r_sync;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_level_d;
        logic             r_press;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync    <= 2'b00;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_press   <= 1'b0;
            end else begin
                r_sync    <= {r_sync[0], w_pb_raw[i]};
                r_level_d <= r_level;
                r_press   <= r_level & ~r_level_d;
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_press[i] = r_press;
    end

    assign w_run_press  = w_press[0];
    assign w_step_press = w_press[1];

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Skip flag lets the core resume from the breakpoint PC without re-hitting it.
    logic r_bp_skip;

    assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_bp_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_skip <= 1'b0;
        end else if (r_state == ST_BREAK && (w_run_press || w_step_press)) begin
            r_bp_skip <= 1'b1;
        end else if (!bp_valid || pc != bp_addr) begin
            r_bp_skip <= 1'b0;
        end
    end
`else
    logic w_unused_bp;

    assign w_bp_hit    = 1'b0;
    assign w_unused_bp = ^{pc, bp_addr, bp_valid};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_bp_hit)         r_state <= ST_BREAK;
                    else if (w_run_press) r_state <= ST_HALT;
                end
                ST_HALT, ST_BREAK: begin
                    if (w_run_press)       r_state <= ST_RUN;
                    else if (w_step_press) r_state <= ST_STEP;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign w_cpu_en = (r_state == ST_RUN && !w_bp_hit) || (r_state == ST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
        end else if (w_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cpu_en    = w_cpu_en;
    assign halted    = (r_state == ST_HALT) || (r_state == ST_BREAK);
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: doc/run_controller.md
# run_controller

Run/halt/single-step controller for the five-stage pipelined core on the board top level. It debounces the raw pushbuttons and sequences the core through a one-cycle clock-enable (`cpu_en`), so the core clock is never gated. It also counts enabled cycles and, when configured, halts the core on a PC breakpoint.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level (N below); minimum 2.
- `PC_W`, default 32: width of `pc` and `bp_addr`.

Ports:
- `clk`  in  1: the single clock; all state is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pb_run`  in  1: raw run/halt toggle button, asynchronous.
- `pb_step`  in  1: raw single-step button, asynchronous.
- `pc`  in  PC_W: current fetch PC of the core.
- `bp_addr`  in  PC_W: breakpoint address.
- `bp_valid`  in  1: breakpoint armed.
- `cpu_en`  out  1: core clock enable; the core advances one cycle per clock with `cpu_en`=1.
- `halted`  out  1: high in HALT or BREAK.
- `state`  out  2: FSM state code.
- `cycle_cnt`  out  32: number of cycles with `cpu_en`=1.

## Operation
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter, cleared whenever the synchronized sample equals the debounced level.
  - When the sample has differed for N consecutive cycles, the debounced level takes the sample value and the counter clears.
  - `press` is a one-cycle pulse on a 0→1 transition of the debounced level.
- FSM state codes: HALT=00, RUN=01, STEP=10, BREAK=11.
- Transitions:
  - RUN: `run_press` → HALT; `bp_hit` → BREAK. `bp_hit` has priority over `run_press`.
  - HALT: `run_press` → RUN; otherwise `step_press` → STEP. Run wins when both pulse together.
  - STEP: always → HALT after one cycle. Presses arriving during STEP are dropped.
  - BREAK: `run_press` → RUN; otherwise `step_press` → STEP.
- `bp_hit` = `bp_valid` & (`pc`==`bp_addr`) & !`bp_skip`.
- `bp_skip`:
  - Set when leaving BREAK.
  - Cleared on the first cycle with `pc`!=`bp_addr` or `bp_valid`=0.
  - Purpose: resume or step from a breakpoint without re-triggering on the same PC.
- `cpu_en` is combinational: (state==RUN & !`bp_hit`) | state==STEP. The core therefore freezes with `pc` equal to `bp_addr`; that instruction has not yet advanced.
- `halted` = state==HALT | state==BREAK, combinational from the state register.
- `cycle_cnt` increments by 1 in every cycle with `cpu_en`=1. It wraps 0xFFFFFFFF→0 silently.

## Timing
- Reset values:
  - state=RUN, so `cpu_en`=1 and `halted`=0 immediately.
  - `cycle_cnt`=0.
  - Debounced levels=0, counters=0, synchronizers=0, `bp_skip`=0.
- `rst` asserted mid-operation, including during STEP or BREAK, forces the reset values asynchronously. No pending press survives.
- Press latency: raw button rises and stays high.
  - Synchronized after 2 cycles.
  - Debounced level updates N cycles later.
  - `press` is high in the following cycle, i.e. N+3 cycles after the raw edge.
  - State changes at the end of the `press` cycle.
- A raw pulse or glitch shorter than N synchronized cycles produces no press. Release also needs N stable cycles before the next press can register.
- STEP: `cpu_en` is high for exactly 1 cycle, then `cpu_en`=0 in HALT.
- Breakpoint: `cpu_en` drops in the same cycle `pc` matches. State reads BREAK from the next cycle.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined:
  - Breakpoint logic as described.
- `RUN_CTRL_BREAKPOINT_EN` undefined:
  - `bp_hit` is constant 0, `bp_skip` is not built, and BREAK is unreachable.
  - `pc`, `bp_addr` and `bp_valid` remain as ports but are ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: pulse `rst` asynchronously mid-cycle → state=01, `cpu_en`=1, `halted`=0, `cycle_cnt`=0 before the next clock edge; `cycle_cnt`=10 after 10 clocks.
- Debounce: hold `pb_run` high 3 cycles, then low → no change. Hold it high 12 cycles → a single press 7 cycles after the edge; state=00, `cpu_en`=0, `cycle_cnt` frozen.
- Step: in HALT, press `pb_step` → exactly one cycle with `cpu_en`=1 in state 10, `cycle_cnt`+1, back to 00. A second press during that cycle is ignored.
- Simultaneous press: in HALT, `pb_run` and `pb_step` rise together → state=01, never 10.
- Breakpoint (macro defined): `bp_valid`=1, `bp_addr`=0x40, `pc` starts at 0 and advances +4 per enabled cycle.
  - `cpu_en`=0 in the cycle `pc`=0x40, then state=11 and `cycle_cnt`=16.
  - `pb_run` press → `cpu_en`=1 with `pc`=0x40, `pc` advances to 0x44, no re-trigger.
- Breakpoint (macro undefined): same stimulus → core never halts; state stays 01.
